// File: rtl/pattern_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_generator_pkg
// Description : Shared states, LFSR constants and default timing for the
//               two-player reaction-game pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_generator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int          c_LFSR_W  = 16;
    // Taps at bits 15, 13, 12 and 10
    localparam logic [15:0] c_LFSR_TAPS = 16'hB400;
    localparam int          c_TIMER_W = 20;

    localparam logic [15:0] c_DEF_SEED         = 16'hACE1;
    localparam int          c_DEF_PRESCALE     = 50;
    localparam int          c_DEF_GAP_LEN      = 200000;
    localparam int          c_DEF_WINDOW_LEN   = 800000;
    localparam int          c_DEF_NUM_PATTERNS = 64;

    function automatic logic [c_LFSR_W-1:0] lfsr_step(input logic [c_LFSR_W-1:0] s);
        return {s[c_LFSR_W-2:0], ^(s & c_LFSR_TAPS)};
    endfunction

    function automatic logic [3:0] next_pattern(input logic [c_LFSR_W-1:0] s);
        logic [c_LFSR_W-1:0] n;
        n = lfsr_step(s);
        return 4'b0001 << n[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_generator_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : 16-bit Fibonacci LFSR with load and step enables.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import pattern_generator_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_step,
    input  logic                i_load,
    input  logic [c_LFSR_W-1:0] i_seed,
    output logic [c_LFSR_W-1:0] o_state
);

    logic [c_LFSR_W-1:0] r_state;

    // Load wins over step so a game start always begins from the seed
    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_state <= i_seed;
        end else if (i_step) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/pattern_generator.sv
`default_nettype none
// ============================================================================
// Module      : pattern_generator
// Description : Game sequencer producing timed one-hot button patterns for
//               two players, separated by fixed gaps, from a seeded LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_generator
    import pattern_generator_pkg::*;
#(
    parameter int          PRESCALE     = c_DEF_PRESCALE,
    parameter int          GAP_LEN      = c_DEF_GAP_LEN,
    parameter int          WINDOW_LEN   = c_DEF_WINDOW_LEN,
    parameter int          NUM_PATTERNS = c_DEF_NUM_PATTERNS,
    parameter logic [15:0] SEED         = c_DEF_SEED
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 game_active,
    input  logic [1:0]           difficulty,
    output logic [3:0]           pattern_a,
    output logic [3:0]           pattern_b,
    output logic                 pattern_valid,
    output logic [c_TIMER_W-1:0] pattern_timer,
    output logic [7:0]           patterns_left,
    output logic                 game_over
);

    localparam int                    c_PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PS_W-1:0]     c_PS_LAST  = c_PS_W'(PRESCALE - 1);
    localparam int                    c_GAP_W    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [c_GAP_W-1:0]    c_GAP_LAST = c_GAP_W'(GAP_LEN - 1);
    localparam logic [c_TIMER_W-1:0]  c_WINDOW   = c_TIMER_W'(WINDOW_LEN);
    localparam logic [7:0]            c_NUM      = 8'(NUM_PATTERNS);

    state_t               r_state,   w_state_nxt;
    logic [c_PS_W-1:0]    r_presc,   w_presc_nxt;
    logic [c_GAP_W-1:0]   r_gap_cnt, w_gap_nxt;
    logic [1:0]           r_diff,    w_diff_nxt;
    logic [3:0]           r_pattern, w_pattern_nxt;
    logic                 r_valid,   w_valid_nxt;
    logic [c_TIMER_W-1:0] r_timer,   w_timer_nxt;
    logic [7:0]           r_left,    w_left_nxt;
    logic                 r_over,    w_over_nxt;

    logic                 w_tick;
    logic                 w_lfsr_step;
    logic                 w_lfsr_load;
    logic [c_LFSR_W-1:0]  w_lfsr;
    logic [c_TIMER_W-1:0] w_win_last;

    lfsr16 u_lfsr (
        .clk     (clock),
        .rst     (reset),
        .i_step  (w_lfsr_step),
        .i_load  (w_lfsr_load),
        .i_seed  (SEED),
        .o_state (w_lfsr)
    );

    assign w_tick     = (r_presc == c_PS_LAST);
    assign w_win_last = (c_WINDOW >> r_diff) - 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_presc_nxt   = w_tick ? '0 : r_presc + 1'b1;
        w_gap_nxt     = r_gap_cnt;
        w_diff_nxt    = r_diff;
        w_pattern_nxt = r_pattern;
        w_valid_nxt   = r_valid;
        w_timer_nxt   = r_timer;
        w_left_nxt    = r_left;
        w_over_nxt    = r_over;
        w_lfsr_step   = 1'b0;
        w_lfsr_load   = 1'b0;

        case (r_state)
            IDLE: begin
                w_presc_nxt   = '0;
                w_gap_nxt     = '0;
                w_pattern_nxt = 4'd0;
                w_valid_nxt   = 1'b0;
                w_timer_nxt   = '0;
                w_over_nxt    = 1'b0;
                if (game_active) begin
                    w_state_nxt = GAP;
                    w_lfsr_load = 1'b1;
                    w_left_nxt  = c_NUM;
                    w_diff_nxt  = (difficulty == 2'd3) ? 2'd2 : difficulty;
                end
            end
            GAP, SHOW: begin
                if (!game_active) begin
                    // Abort: back to idle with every output cleared
                    w_state_nxt   = IDLE;
                    w_presc_nxt   = '0;
                    w_gap_nxt     = '0;
                    w_pattern_nxt = 4'd0;
                    w_valid_nxt   = 1'b0;
                    w_timer_nxt   = '0;
                    w_left_nxt    = 8'd0;
                    w_over_nxt    = 1'b0;
                end else if (w_tick && (r_state == GAP)) begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        w_state_nxt   = SHOW;
                        w_presc_nxt   = '0;
                        w_gap_nxt     = '0;
                        w_lfsr_step   = 1'b1;
                        w_pattern_nxt = next_pattern(w_lfsr);
                        w_valid_nxt   = 1'b1;
                        w_timer_nxt   = '0;
                    end else begin
                        w_gap_nxt = r_gap_cnt + 1'b1;
                    end
                end else if (w_tick) begin
                    if (r_timer == w_win_last) begin
                        w_presc_nxt   = '0;
                        w_gap_nxt     = '0;
                        w_pattern_nxt = 4'd0;
                        w_valid_nxt   = 1'b0;
                        w_timer_nxt   = '0;
                        w_left_nxt    = (r_left != 8'd0) ? r_left - 8'd1 : 8'd0;
                        if (r_left <= 8'd1) begin
                            w_state_nxt = DONE;
                            w_over_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = GAP;
                        end
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
            end
            DONE: begin
                w_presc_nxt = '0;
                w_over_nxt  = 1'b1;
                if (!game_active) begin
                    w_state_nxt = IDLE;
                    w_over_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_presc   <= '0;
            r_gap_cnt <= '0;
            r_diff    <= 2'd0;
            r_pattern <= 4'd0;
            r_valid   <= 1'b0;
            r_timer   <= '0;
            r_left    <= 8'd0;
            r_over    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_diff    <= w_diff_nxt;
            r_pattern <= w_pattern_nxt;
            r_valid   <= w_valid_nxt;
            r_timer   <= w_timer_nxt;
            r_left    <= w_left_nxt;
            r_over    <= w_over_nxt;
        end
    end

    assign pattern_a     = r_pattern;
    assign pattern_b     = r_pattern;
    assign pattern_valid = r_valid;
    assign pattern_timer = r_timer;
    assign patterns_left = r_left;
    assign game_over     = r_over;

endmodule
`default_nettype wire

// File: tb/tb_pattern_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_generator
// Description : Self-checking bench for pattern_generator with short timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_generator;

    logic        clock = 1'b0;
    logic        reset;
    logic        game_active;
    logic [1:0]  difficulty;
    logic [3:0]  pattern_a;
    logic [3:0]  pattern_b;
    logic        pattern_valid;
    logic [19:0] pattern_timer;
    logic [7:0]  patterns_left;
    logic        game_over;

    int n_checks = 0;
    int n_fail   = 0;

    pattern_generator #(
        .PRESCALE     (2),
        .GAP_LEN      (4),
        .WINDOW_LEN   (8),
        .NUM_PATTERNS (3),
        .SEED         (16'hACE1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .game_active   (game_active),
        .difficulty    (difficulty),
        .pattern_a     (pattern_a),
        .pattern_b     (pattern_b),
        .pattern_valid (pattern_valid),
        .pattern_timer (pattern_timer),
        .patterns_left (patterns_left),
        .game_over     (game_over)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        ga;
        logic [1:0]  diff;
        int          n;
        logic [37:0] exp;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [37:0] ob(input logic v, input logic [3:0] p,
                                       input logic [19:0] t, input logic [7:0] l,
                                       input logic o);
        return {v, p, p, t, l, o};
    endfunction

    function automatic logic [37:0] outs();
        return {pattern_valid, pattern_a, pattern_b, pattern_timer, patterns_left, game_over};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_level(input logic lvl, input int budget, input string tag);
        int i;
        i = 0;
        while (pattern_valid !== lvl && i < budget) begin
            tick(1);
            i++;
        end
        check(tag, {63'd0, pattern_valid}, {63'd0, lvl});
    endtask

    task automatic measure_width(input int exp, input string tag);
        int w;
        w = 0;
        while (pattern_valid === 1'b1 && w < 100) begin
            w++;
            tick(1);
        end
        check(tag, 64'(w), 64'(exp));
    endtask

    initial begin
        reset       = 1'b1;
        game_active = 1'b0;
        difficulty  = 2'd0;

        // Cycle-by-cycle walk through one whole game; counts are edges since start
        vecs[0]  = '{1'b1, 1'b1, 2'd0, 2,  ob(1'b0, 4'h0, 20'd0, 8'd0, 1'b0)};
        vecs[1]  = '{1'b0, 1'b1, 2'd0, 1,  ob(1'b0, 4'h0, 20'd0, 8'd3, 1'b0)};
        vecs[2]  = '{1'b0, 1'b1, 2'd0, 7,  ob(1'b0, 4'h0, 20'd0, 8'd3, 1'b0)};
        vecs[3]  = '{1'b0, 1'b1, 2'd0, 1,  ob(1'b1, 4'h8, 20'd0, 8'd3, 1'b0)};
        vecs[4]  = '{1'b0, 1'b1, 2'd0, 1,  ob(1'b1, 4'h8, 20'd0, 8'd3, 1'b0)};
        vecs[5]  = '{1'b0, 1'b1, 2'd0, 1,  ob(1'b1, 4'h8, 20'd1, 8'd3, 1'b0)};
        vecs[6]  = '{1'b0, 1'b1, 2'd0, 12, ob(1'b1, 4'h8, 20'd7, 8'd3, 1'b0)};
        vecs[7]  = '{1'b0, 1'b1, 2'd0, 1,  ob(1'b1, 4'h8, 20'd7, 8'd3, 1'b0)};
        vecs[8]  = '{1'b0, 1'b1, 2'd0, 1,  ob(1'b0, 4'h0, 20'd0, 8'd2, 1'b0)};
        vecs[9]  = '{1'b0, 1'b1, 2'd0, 8,  ob(1'b1, 4'h8, 20'd0, 8'd2, 1'b0)};
        vecs[10] = '{1'b0, 1'b1, 2'd0, 39, ob(1'b1, 4'h8, 20'd7, 8'd1, 1'b0)};
        vecs[11] = '{1'b0, 1'b1, 2'd0, 1,  ob(1'b0, 4'h0, 20'd0, 8'd0, 1'b1)};
        vecs[12] = '{1'b0, 1'b1, 2'd0, 5,  ob(1'b0, 4'h0, 20'd0, 8'd0, 1'b1)};
        vecs[13] = '{1'b0, 1'b0, 2'd0, 1,  ob(1'b0, 4'h0, 20'd0, 8'd0, 1'b0)};
        vecs[14] = '{1'b0, 1'b0, 2'd0, 3,  ob(1'b0, 4'h0, 20'd0, 8'd0, 1'b0)};

        tick(1);
        for (int i = 0; i < 15; i++) begin
            reset       = vecs[i].rst;
            game_active = vecs[i].ga;
            difficulty  = vecs[i].diff;
            tick(vecs[i].n);
            check($sformatf("vec%0d", i), {26'd0, outs()}, {26'd0, vecs[i].exp});
        end

        // Abort during the second pattern
        game_active = 1'b1;
        wait_level(1'b1, 50, "abort_show1");
        wait_level(1'b0, 50, "abort_gap2");
        wait_level(1'b1, 50, "abort_show2");
        check("abort_left", {56'd0, patterns_left}, 64'd2);
        tick(2);
        game_active = 1'b0;
        tick(1);
        check("abort_outputs", {26'd0, outs()}, 64'd0);
        tick(20);
        check("abort_no_over", {63'd0, game_over}, 64'd0);

        // Fresh game repeats the same LFSR sequence
        game_active = 1'b1;
        tick(9);
        check("restart_first", {26'd0, outs()}, {26'd0, ob(1'b1, 4'h8, 20'd0, 8'd3, 1'b0)});
        check("restart_lfsr1", {48'd0, dut.w_lfsr}, 64'h59C3);
        wait_level(1'b0, 50, "restart_gap2");
        wait_level(1'b1, 50, "restart_show2");
        check("restart_lfsr2", {48'd0, dut.w_lfsr}, 64'hB387);
        check("restart_pat2", {60'd0, pattern_a}, 64'h8);
        wait_level(1'b0, 50, "restart_gap3");
        wait_level(1'b1, 50, "restart_show3");
        check("restart_lfsr3", {48'd0, dut.w_lfsr}, 64'h670F);
        for (int i = 0; i < 100 && game_over !== 1'b1; i++) tick(1);
        check("restart_over", {55'd0, game_over, patterns_left}, {55'd0, 1'b1, 8'd0});
        game_active = 1'b0;
        tick(2);

        // Difficulty shrinks the window and is latched at game start
        difficulty  = 2'd2;
        game_active = 1'b1;
        wait_level(1'b1, 50, "diff2_show");
        measure_width(4, "diff2_width");
        difficulty = 2'd0;
        wait_level(1'b1, 50, "diff_latch_show");
        measure_width(4, "diff_latch_width");
        game_active = 1'b0;
        tick(2);
        difficulty  = 2'd3;
        game_active = 1'b1;
        wait_level(1'b1, 50, "diff3_show");
        measure_width(4, "diff3_width");
        game_active = 1'b0;
        tick(2);
        difficulty  = 2'd1;
        game_active = 1'b1;
        wait_level(1'b1, 50, "diff1_show");
        measure_width(8, "diff1_width");
        game_active = 1'b0;
        tick(2);

        // Reset in the middle of a pattern, then restart
        difficulty  = 2'd0;
        game_active = 1'b1;
        wait_level(1'b1, 50, "rst_show");
        tick(5);
        reset = 1'b1;
        tick(1);
        check("rst_outputs", {26'd0, outs()}, 64'd0);
        check("rst_lfsr_seed", {48'd0, dut.w_lfsr}, 64'hACE1);
        reset = 1'b0;
        tick(9);
        check("rst_restart", {26'd0, outs()}, {26'd0, ob(1'b1, 4'h8, 20'd0, 8'd3, 1'b0)});
        check("rst_restart_lfsr", {48'd0, dut.w_lfsr}, 64'h59C3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
